// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Optional PS2_TX_ACK_CHECK_EN: a device NACK on the ack clock drops the byte with tx_err instead of tx_done.
module ps2_host_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       key_clk_in,
    input  logic       key_data_in,
    output logic       key_clk_oe,
    output logic       key_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int INH = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TMO = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int CW  = $clog2((INH > TMO ? INH : TMO) + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INH - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, ACK, WAITIDLE, FIN} state_t;

    state_t          state;
    logic [7:0]      byte_r;
    logic            par;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_cnt;
    logic            kc_s1, kc_s2, kc_s3, kd_s1, kd_s2;
    logic            fe;

    assign fe      = kc_s3 & ~kc_s2;
    assign tx_busy = ~tx_ready;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            byte_r      <= '0;
            par         <= 1'b0;
            cnt         <= '0;
            bit_cnt     <= '0;
            kc_s1       <= 1'b1;
            kc_s2       <= 1'b1;
            kc_s3       <= 1'b1;
            kd_s1       <= 1'b1;
            kd_s2       <= 1'b1;
            tx_ready    <= 1'b1;
            key_clk_oe  <= 1'b0;
            key_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            kc_s1   <= key_clk_in;
            kc_s2   <= kc_s1;
            kc_s3   <= kc_s2;
            kd_s1   <= key_data_in;
            kd_s2   <= kd_s1;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                IDLE: if (tx_valid) begin
                    byte_r     <= tx_data;
                    par        <= ~^tx_data;
                    cnt        <= '0;
                    key_clk_oe <= 1'b1;
                    tx_ready   <= 1'b0;
                    state      <= INHIBIT;
                end
                INHIBIT: if (cnt == INH_LAST) begin
                    key_data_oe <= 1'b1;
                    state       <= REQ;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                REQ: begin
                    key_clk_oe <= 1'b0;
                    bit_cnt    <= '0;
                    cnt        <= '0;
                    state      <= DATA;
                end
                DATA, ACK, WAITIDLE: begin
                    cnt <= fe ? '0 : cnt + CW'(1);
                    if (state == WAITIDLE && kc_s2 && kd_s2) begin
                        tx_done <= 1'b1;
                        state   <= FIN;
                    end else if (fe && state == DATA) begin
                        // fe 1..8 data LSB first, fe 9 parity, fe 10 releases for the stop bit
                        bit_cnt     <= bit_cnt + 4'd1;
                        key_data_oe <= bit_cnt == 4'd8 ? ~par : bit_cnt == 4'd9 ? 1'b0 : ~byte_r[bit_cnt[2:0]];
                        if (bit_cnt == 4'd9) state <= ACK;
                    end else if (fe && state == ACK) begin
`ifdef PS2_TX_ACK_CHECK_EN
                        if (kd_s2) begin
                            tx_err <= 1'b1;
                            state  <= FIN;
                        end else begin
                            state <= WAITIDLE;
                        end
`else
                        state <= WAITIDLE;
`endif
                    end else if (!fe && cnt == TMO_LAST) begin
                        key_clk_oe  <= 1'b0;
                        key_data_oe <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= FIN;
                    end
                end
                // one spare cycle keeps done/err pulses apart from the rise of tx_ready
                FIN: begin
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed vectors for ps2_host_tx against a clock-generating PS/2 device model.
// Runs at a 1 MHz system clock so inhibit is 100 cycles and timeout 15000 cycles.
module tb_ps2_host_tx;
    localparam int CLK_HZ = 1_000_000;
    localparam int INH    = 100;
    localparam int TMO    = 15000;
    localparam int HALF   = 40;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, key_clk_in, key_data_in, key_clk_oe, key_data_oe;
    logic       tx_busy, tx_done, tx_err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign key_clk_in  = dev_clk & ~key_clk_oe;
    assign key_data_in = dev_data & ~key_data_oe;

    always #5 Clk = ~Clk;

    ps2_host_tx #(.CLK_HZ(CLK_HZ), .INHIBIT_US(100), .TIMEOUT_US(15000)) dut (
        .Clk(Clk), .Rst(Rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .key_clk_in(key_clk_in), .key_data_in(key_data_in), .key_clk_oe(key_clk_oe),
        .key_data_oe(key_data_oe), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    int n_cmp = 0, n_bad = 0, n_done = 0, n_err = 0, n_overlap = 0;

    always @(negedge Clk) begin
        if (tx_done) n_done++;
        if (tx_err) n_err++;
        if ((tx_done && tx_err) || ((tx_done || tx_err) && tx_ready)) n_overlap++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers a byte, counts inhibit-only cycles, returns once the clock is released
    task automatic start_frame(input logic [7:0] d, input bit hold, output int inh);
        int n;
        @(negedge Clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge Clk);
        if (!hold) tx_valid = 1'b0;
        inh = 0;
        while (key_clk_oe && !key_data_oe && inh < 10000) begin
            inh++;
            @(negedge Clk);
        end
        n = 0;
        while (key_clk_oe && n < 100) begin
            n++;
            @(negedge Clk);
        end
    endtask

    // Device: samples the line before each of 11 falling edges, presents ack before the last one
    task automatic device(input logic ack, output logic [10:0] bits);
        for (int k = 0; k < 11; k++) begin
            repeat (HALF) @(negedge Clk);
            bits[k] = key_data_in;
            if (k == 10) begin
                dev_data = ack;
                repeat (5) @(negedge Clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge Clk);
            dev_clk = 1'b1;
        end
        repeat (10) @(negedge Clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!tx_ready && n < 2000) begin
            n++;
            @(negedge Clk);
        end
        check(name, tx_ready, 1);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic [10:0] frame;
        logic        done;
        logic        err;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        logic [10:0] bits;
        int          inh, d0, e0, n;
        bit          seen_ready;

        vecs[0] = '{8'hED, 1'b0, 11'h7DA, 1'b1, 1'b0};
        vecs[1] = '{8'hF4, 1'b0, 11'h5E8, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 11'h7FE, !ACK_CHK, ACK_CHK};
        vecs[3] = '{8'h00, 1'b0, 11'h600, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b0, 11'h402, 1'b1, 1'b0};

        repeat (3) @(negedge Clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_clk_oe", key_clk_oe, 0);
        check("rst_data_oe", key_data_oe, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        Rst = 1'b1;
        repeat (3) @(negedge Clk);

        foreach (vecs[i]) begin
            d0 = n_done;
            e0 = n_err;
            start_frame(vecs[i].data, 1'b0, inh);
            check($sformatf("inhibit_%0h", vecs[i].data), inh, INH);
            check($sformatf("busy_%0h", vecs[i].data), tx_busy, 1);
            device(vecs[i].ack, bits);
            check($sformatf("frame_%0h", vecs[i].data), bits, vecs[i].frame);
            wait_ready($sformatf("ready_%0h", vecs[i].data));
            check($sformatf("done_%0h", vecs[i].data), n_done - d0, vecs[i].done);
            check($sformatf("err_%0h", vecs[i].data), n_err - e0, vecs[i].err);
        end
        check("pulse_overlap", n_overlap, 0);

        // tx_valid held, tx_data changed mid-frame; next byte only after IDLE, then reset mid-INHIBIT
        d0 = n_done;
        start_frame(8'hA5, 1'b1, inh);
        tx_data = 8'h3C;
        device(1'b0, bits);
        check("held_frame", bits, 11'h74A);
        seen_ready = 1'b0;
        n = 0;
        while (!key_clk_oe && n < 500) begin
            if (tx_ready) seen_ready = 1'b1;
            n++;
            @(negedge Clk);
        end
        check("held_ready_seen", seen_ready, 1);
        check("held_restart", key_clk_oe, 1);
        check("held_done", n_done - d0, 1);
        repeat (10) @(negedge Clk);
        check("mid_inhibit", key_clk_oe, 1);
        #1 Rst = 1'b0;
        #1;
        check("async_clk_oe", key_clk_oe, 0);
        check("async_data_oe", key_data_oe, 0);
        check("async_ready", tx_ready, 1);
        tx_valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        check("post_rst_ready", tx_ready, 1);
        check("post_rst_idle", key_clk_oe, 0);

        // silent device: timeout counted from clock release
        d0 = n_done;
        e0 = n_err;
        start_frame(8'h55, 1'b0, inh);
        n = 0;
        while (!tx_err && n < 20000) begin
            n++;
            @(negedge Clk);
        end
        check("timeout_cycles", n, TMO);
        check("timeout_clk_oe", key_clk_oe, 0);
        check("timeout_data_oe", key_data_oe, 0);
        wait_ready("timeout_ready");
        check("timeout_err", n_err - e0, 1);
        check("timeout_done", n_done - d0, 0);
        check("final_overlap", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
